slice_serializer: RTL and testbench

//  Parametrised successor of the fixed 3-bit slice input: accepts a DATA_WIDTH-bit word over a

---
 rtl/slice_pkg.sv | 17 +
 rtl/slice_index_counter.sv | 31 +++
 rtl/slice_serializer.sv | 104 ++++++++++
 tb/tb_slice_serializer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_pkg.sv
// Shared types and sizing helpers for the slice serializer/deserializer family.
package slice_pkg;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } slice_state_t;

  function automatic int unsigned num_slices(input int unsigned dw, input int unsigned sw);
    return (sw == 32'd0) ? 32'd1 : dw / sw;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/slice_index_counter.sv
// Slice position counter with a registered flag marking the final slice of a word.
module slice_index_counter #(
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned NUM_SLICES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic             incr,
  output logic [IDX_W-1:0] index,
  output logic             last
);

  localparam int unsigned LAST_IDX = NUM_SLICES - 1;

  // last is precomputed on every load/step so it is valid in the same cycle as index
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      index <= '0;
      last  <= 1'b0;
    end else if (start) begin
      index <= '0;
      last  <= (NUM_SLICES == 32'd1);
    end else if (incr) begin
      index <= index + IDX_W'(1);
      last  <= ((index + IDX_W'(1)) == IDX_W'(LAST_IDX));
    end
  end

endmodule

// File: rtl/slice_serializer.sv
// Splits a DATA_WIDTH word into SLICE_WIDTH slices over valid/ready, gap-free across words.
module slice_serializer
  import slice_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH  = 12,
  parameter int unsigned  SLICE_WIDTH = 3,
  parameter bit           MSB_FIRST   = 1'b1,
  localparam int unsigned NUM_SLICES  = num_slices(DATA_WIDTH, SLICE_WIDTH),
  localparam int unsigned IDX_W       = idx_width(NUM_SLICES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SLICE_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]       out_index,
  output logic                   out_last
);

  if (SLICE_WIDTH == 0 || (DATA_WIDTH % SLICE_WIDTH) != 0) begin : g_bad_cfg
    $error("slice_serializer: DATA_WIDTH must be a non-zero multiple of SLICE_WIDTH");
  end

  slice_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_shift;
  logic                  capture, advance, drain;

  // Emission order is fixed at elaboration: the presented slice always sits at one end
  if (MSB_FIRST) begin : g_msb
    assign sreg_shift = sreg_q << SLICE_WIDTH;
    assign out_data   = sreg_q[DATA_WIDTH-1 -: SLICE_WIDTH];
  end else begin : g_lsb
    assign sreg_shift = sreg_q >> SLICE_WIDTH;
    assign out_data   = sreg_q[SLICE_WIDTH-1:0];
  end

  // Next state and handshake decode
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    capture  = 1'b0;
    advance  = 1'b0;
    drain    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        in_ready = out_ready & out_last;
        if (out_ready) begin
          if (!out_last) begin
            advance = 1'b1;
          end else if (in_valid) begin
            capture = 1'b1;
          end else begin
            drain   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clearing the register on drain keeps out_data at zero whenever nothing is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      out_valid <= 1'b0;
      sreg_q    <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == S_SHIFT);
      if (capture) begin
        sreg_q <= in_data;
      end else if (advance) begin
        sreg_q <= sreg_shift;
      end else if (drain) begin
        sreg_q <= '0;
      end
    end
  end

  slice_index_counter #(
    .IDX_W      (IDX_W),
    .NUM_SLICES (NUM_SLICES)
  ) u_index (
    .clk   (clk),
    .rst   (rst),
    .clear (drain),
    .start (capture),
    .incr  (advance),
    .index (out_index),
    .last  (out_last)
  );

endmodule

// File: tb/tb_slice_serializer.sv
// Self-checking bench: MSB-first, LSB-first (12/3) and single-slice (8/8) serializers.
module tb_slice_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, out_ready;
  logic [11:0] in_data;
  logic        a_in_ready, a_out_valid, a_out_last;
  logic [2:0]  a_out_data;
  logic [1:0]  a_out_index;
  logic        b_in_ready, b_out_valid, b_out_last;
  logic [2:0]  b_out_data;
  logic [1:0]  b_out_index;
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
  logic [7:0]  c_in_data, c_out_data;
  logic [0:0]  c_out_index;

  int n_cmp = 0;
  int n_bad = 0;

  slice_serializer #(.DATA_WIDTH(12), .SLICE_WIDTH(3), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_index(a_out_index), .out_last(a_out_last));

  slice_serializer #(.DATA_WIDTH(12), .SLICE_WIDTH(3), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_index(b_out_index), .out_last(b_out_last));

  slice_serializer #(.DATA_WIDTH(8), .SLICE_WIDTH(8), .MSB_FIRST(1'b1)) u_one (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_index(c_out_index), .out_last(c_out_last));

  // Slice k in emission order of a 12-bit word cut into four 3-bit pieces
  function automatic logic [2:0] ref_slice(input logic [11:0] w, input int k, input bit msb);
    int pos = msb ? 3 - k : k;
    return 3'((w >> (3 * pos)) & 12'h7);
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp += 7;
    if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", a_out_valid); end
    if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    if (a_out_index !== 2'd0) begin n_bad++; $display("FAIL reset_index: got %0d want 0", a_out_index); end
    if (a_out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", a_out_last); end
    if (a_out_data !== 3'd0 || b_out_data !== 3'd0) begin
      n_bad++; $display("FAIL reset_data: got %0h/%0h want 0", a_out_data, b_out_data);
    end
    if (c_out_valid !== 1'b0 || c_out_last !== 1'b0) begin
      n_bad++; $display("FAIL reset_one: got valid %b last %b want 0 0", c_out_valid, c_out_last);
    end
    if (c_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_one_ready: got %b want 1", c_in_ready); end
  endtask

  task automatic test_single(input logic [11:0] w);
    @(negedge clk);
    in_valid = 1'b1; in_data = w; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_idle: got ready %b valid %b want 1 0", a_in_ready, a_out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0; in_data = ~w;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp += 5;
      if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid k=%0d: got %b want 1", k, a_out_valid); end
      if (a_out_data !== ref_slice(w, k, 1'b1)) begin
        n_bad++; $display("FAIL single_msb w=%h k=%0d: got %0d want %0d", w, k, a_out_data, ref_slice(w, k, 1'b1));
      end
      if (b_out_data !== ref_slice(w, k, 1'b0)) begin
        n_bad++; $display("FAIL single_lsb w=%h k=%0d: got %0d want %0d", w, k, b_out_data, ref_slice(w, k, 1'b0));
      end
      if (a_out_index !== 2'(k) || a_out_last !== (k == 3)) begin
        n_bad++; $display("FAIL single_idx k=%0d: got idx %0d last %b", k, a_out_index, a_out_last);
      end
      if (a_in_ready !== (k == 3)) begin
        n_bad++; $display("FAIL single_in_ready k=%0d: got %b want %b", k, a_in_ready, (k == 3));
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_out_data !== 3'd0 || b_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_done: got valid %b data %0d want 0 0", a_out_valid, a_out_data);
    end
  endtask

  task automatic test_back_to_back(input int nw);
    logic [11:0] words[$];
    int wi = 0;
    int b = 0;
    int cyc = 0;
    bit exp_valid;
    words.push_back(12'hA5C);
    words.push_back(12'h123);
    for (int i = 2; i < nw; i++) words.push_back(12'($urandom));
    while (b < nw * 4 && cyc < 200) begin
      @(negedge clk);
      in_valid = (wi < nw); in_data = (wi < nw) ? words[wi] : 12'h000; out_ready = 1'b1;
      #1;
      exp_valid = (wi > 0);
      n_cmp += 2;
      if (a_out_valid !== exp_valid) begin n_bad++; $display("FAIL b2b_valid beat=%0d: got %b want %b", b, a_out_valid, exp_valid); end
      if (a_in_ready !== (!exp_valid || (b % 4 == 3))) begin
        n_bad++; $display("FAIL b2b_in_ready beat=%0d: got %b want %b", b, a_in_ready, (!exp_valid || (b % 4 == 3)));
      end
      if (exp_valid) begin
        n_cmp += 3;
        if (a_out_data !== ref_slice(words[b / 4], b % 4, 1'b1)) begin
          n_bad++; $display("FAIL b2b_msb beat=%0d: got %0d want %0d", b, a_out_data, ref_slice(words[b / 4], b % 4, 1'b1));
        end
        if (b_out_data !== ref_slice(words[b / 4], b % 4, 1'b0)) begin
          n_bad++; $display("FAIL b2b_lsb beat=%0d: got %0d want %0d", b, b_out_data, ref_slice(words[b / 4], b % 4, 1'b0));
        end
        if (a_out_index !== 2'(b % 4) || a_out_last !== (b % 4 == 3)) begin
          n_bad++; $display("FAIL b2b_idx beat=%0d: got idx %0d last %b", b, a_out_index, a_out_last);
        end
        b++;
      end
      if (in_valid && (!exp_valid || (b % 4 == 0))) wi++;
      cyc++;
    end
    n_cmp++;
    if (b != nw * 4) begin n_bad++; $display("FAIL b2b_timeout: got %0d beats want %0d", b, nw * 4); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got valid %b want 0", a_out_valid); end
  endtask

  task automatic test_stall(input logic [11:0] w);
    int b = 0;
    int i = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = w; out_ready = 1'b0;
    while (b < 4 && i < 40) begin
      @(negedge clk);
      out_ready = (i % 3 == 0);
      in_valid = (b < 3); in_data = ~w;
      #1;
      n_cmp += 4;
      if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid i=%0d: got %b want 1", i, a_out_valid); end
      if (a_out_data !== ref_slice(w, b, 1'b1) || b_out_data !== ref_slice(w, b, 1'b0)) begin
        n_bad++; $display("FAIL stall_data i=%0d: got %0d/%0d want %0d/%0d", i, a_out_data, b_out_data,
                          ref_slice(w, b, 1'b1), ref_slice(w, b, 1'b0));
      end
      if (a_out_index !== 2'(b)) begin n_bad++; $display("FAIL stall_index i=%0d: got %0d want %0d", i, a_out_index, b); end
      if (a_in_ready !== (out_ready && b == 3)) begin
        n_bad++; $display("FAIL stall_in_ready i=%0d: got %b want %b", i, a_in_ready, (out_ready && b == 3));
      end
      if (out_ready) b++;
      i++;
    end
    n_cmp++;
    if (b != 4) begin n_bad++; $display("FAIL stall_timeout: got %0d beats want 4", b); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_cmp++;
    if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_end: got valid %b want 0", a_out_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_data = 12'hA5C; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (a_out_data !== 3'd1 || a_out_index !== 2'd1) begin
      n_bad++; $display("FAIL rstmid_pre: got %0d idx %0d want 1 idx 1", a_out_data, a_out_index);
    end
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp += 2;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_state: got valid %b ready %b want 0 1", a_out_valid, a_in_ready);
    end
    if (a_out_index !== 2'd0 || a_out_data !== 3'd0) begin
      n_bad++; $display("FAIL rstmid_outs: got idx %0d data %0d want 0 0", a_out_index, a_out_data);
    end
    test_single(12'h001);
  endtask

  task automatic test_random(input int n);
    logic [11:0] q[$];
    int qi = 0;
    bit ev, er;
    for (int i = 0; i < n + 40; i++) begin
      @(negedge clk);
      in_valid  = (i < n) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = 12'($urandom);
      out_ready = (i < n) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      ev = (q.size() > 0);
      er = !ev || (out_ready && qi == 3);
      n_cmp += 2;
      if (a_out_valid !== ev || b_out_valid !== ev) begin
        n_bad++; $display("FAIL rand_valid i=%0d: got %b/%b want %b", i, a_out_valid, b_out_valid, ev);
      end
      if (a_in_ready !== er) begin n_bad++; $display("FAIL rand_in_ready i=%0d: got %b want %b", i, a_in_ready, er); end
      n_cmp++;
      if (ev) begin
        if (a_out_data !== ref_slice(q[0], qi, 1'b1) || b_out_data !== ref_slice(q[0], qi, 1'b0) ||
            a_out_index !== 2'(qi) || a_out_last !== (qi == 3)) begin
          n_bad++; $display("FAIL rand_beat i=%0d: got %0d/%0d idx %0d last %b want %0d/%0d idx %0d", i,
                            a_out_data, b_out_data, a_out_index, a_out_last,
                            ref_slice(q[0], qi, 1'b1), ref_slice(q[0], qi, 1'b0), qi);
        end
      end else if (a_out_data !== 3'd0 || b_out_data !== 3'd0) begin
        n_bad++; $display("FAIL rand_idle_data i=%0d: got %0d/%0d want 0", i, a_out_data, b_out_data);
      end
      if (ev && out_ready) begin
        qi++;
        if (qi == 4) begin
          void'(q.pop_front());
          qi = 0;
        end
      end
      if (in_valid && er) q.push_back(in_data);
    end
  endtask

  task automatic test_single_slice();
    logic [7:0] q[$];
    bit ev, er;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      c_in_valid  = (i < 12) ? 1'b1 : (i < 56) ? 1'($urandom_range(0, 1)) : 1'b0;
      c_in_data   = 8'($urandom);
      c_out_ready = (i < 12 || i >= 56) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      ev = (q.size() > 0);
      er = !ev || c_out_ready;
      n_cmp += 2;
      if (c_out_valid !== ev) begin n_bad++; $display("FAIL one_valid i=%0d: got %b want %b", i, c_out_valid, ev); end
      if (c_in_ready !== er) begin n_bad++; $display("FAIL one_in_ready i=%0d: got %b want %b", i, c_in_ready, er); end
      if (ev) begin
        n_cmp++;
        if (c_out_data !== q[0] || c_out_last !== 1'b1 || c_out_index !== 1'b0) begin
          n_bad++; $display("FAIL one_beat i=%0d: got %h last %b idx %0d want %h last 1 idx 0", i,
                            c_out_data, c_out_last, c_out_index, q[0]);
        end
      end
      if (ev && c_out_ready) void'(q.pop_front());
      if (c_in_valid && er) q.push_back(c_in_data);
    end
    c_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single(12'hA5C);
    for (int i = 0; i < 3; i++) test_single(12'($urandom));
    test_back_to_back(5);
    test_stall(12'hFFF);
    test_stall(12'($urandom));
    test_reset_mid();
    test_random(300);
    test_single_slice();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
